spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Byte-level transaction controller that sits behind the SPI slave shift engine. It frames the received byte stream into command and data phases and owns a small register file that configures the up-counter/LED logic. It sequences register writes and reads with address auto-increment, and supplies the next transmit byte for read-back.

Parameters:
NUM_REGS, 8, number of 8-bit registers (2..16); address width is fixed at 4 bits.
ID_VALUE, 8'hA5, constant returned by register 0, which is read-only.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ss_active  input  1  high while the SPI frame is selected (slave chip-select, synchronised)
rx_data  input  8  byte received from the SPI slave
rx_done  input  1  1-cycle pulse: rx_data is valid
tx_data  output  8  byte to shift out on the next SPI byte
tx_load  output  1  1-cycle pulse: tx_data updated
wr_en  output  1  1-cycle register-write strobe
wr_addr  output  4  address of the write
wr_data  output  8  data of the write
regs_out  output  NUM_REGS*8  flattened register file; reg i is at [8i+7:8i]
busy  output  1  high in any state other than IDLE
addr_err  output  1  1-cycle pulse on a command byte with address >= NUM_REGS

Behaviour:
- Reset (reset=0, async): state=IDLE; all regs_out=0 except reg0 field=ID_VALUE; tx_data=0; tx_load, wr_en, addr_err=0; wr_addr, wr_data=0; addr pointer=0.
- Command byte format: bit7=1 write / 0 read; bits[6:4] ignored; bits[3:0]=start address.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE -> CMD when ss_active=1.
  - CMD on rx_done: latch addr=rx_data[3:0].
    - If bit7=1 -> WDATA.
    - Else -> RDATA; in the same transition tx_data=reg[addr] (0x00 if addr >= NUM_REGS) and tx_load pulses 1 cycle later (registered).
  - WDATA on rx_done:
    - If 1<=addr<NUM_REGS: reg[addr]<=rx_data, wr_en=1, wr_addr=addr, wr_data=rx_data (registered outputs, 1-cycle latency from rx_done).
    - addr=0 (read-only) or out of range: no write, no wr_en.
    - Then advance addr.
  - RDATA on rx_done: rx_data is ignored (dummy); advance addr; tx_data=reg[new addr]; tx_load pulse.
  - Any state -> IDLE on the cycle after ss_active=0. Any in-flight byte is discarded; partial frames leave earlier completed writes intact.
- Address advance: addr=(addr==NUM_REGS-1)?0:addr+1. An out-of-range addr does not advance; it holds, writes stay ignored and reads return 0x00.
- addr_err: pulses once per command byte with addr >= NUM_REGS; the frame continues.
- Simultaneous ss_active=0 and rx_done: ss drop wins; the byte is neither written nor counted.
- ss_active held high after a transition to IDLE: re-enter CMD next cycle; each frame has exactly one command byte.
- Frame with ss_active=1 but no bytes: no side effects.
- busy = (state != IDLE).
- Only one rx_done per cycle; back-to-back rx_done pulses on consecutive cycles must be handled.

Test Plan:
- Reset then read reg0: frame [0x00, dummy] -> tx_data=0xA5 with tx_load pulse after the command byte; regs_out[7:0]=0xA5, others 0.
- Burst write: frame [0x82, 0x11, 0x22, 0x33] -> wr_en pulses at addr 2, 3, 4 with data 0x11, 0x22, 0x33; regs_out matches.
- Wrap: NUM_REGS=8, frame [0x87, 0xAA, 0xBB, 0xCC] -> reg7=0xAA, reg0 unchanged (0xA5, no wr_en), reg1=0xCC.
- Burst read: after the previous test, frame [0x06, d, d, d] -> tx_data sequence reg6, 0xAA, 0xA5, 0xCC, each with a tx_load pulse.
- Out of range: frame [0x8C, 0x55] -> addr_err pulse; no wr_en; regs_out unchanged. Read [0x0C, d] -> tx_data=0x00.
- Abort/reset: ss_active drops in the same cycle as the rx_done of the second data byte -> only the first byte is written, FSM returns to IDLE. Async reset mid-WDATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Byte-level command/data framer behind an SPI slave: owns a small register file,
// sequences auto-incrementing writes and reads, and supplies the next transmit byte.
module spi_reg_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ss_active_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_done_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_load_o,
  output logic                  wr_en_o,
  output logic [3:0]            wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic [NUM_REGS*8-1:0] regs_out_o,
  output logic                  busy_o,
  output logic                  addr_err_o
);

  typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

  localparam logic [4:0] NumRegsW = 5'(NUM_REGS);
  localparam logic [3:0] LastAddr = 4'(NUM_REGS - 1);

  state_e state_q, state_d;

  logic [3:0] addr_q, addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_load_q, tx_load_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       addr_err_q, addr_err_d;

  // Register 0 is the constant ID, so only 1..NUM_REGS-1 need storage.
  logic [7:0] regs_q [NUM_REGS-1:1];

  logic       byte_valid;
  logic       reg_we;
  logic [3:0] addr_adv;
  logic [3:0] rd_addr;
  logic [7:0] rd_byte;

  function automatic logic in_range(input logic [3:0] a);
    return {1'b0, a} < NumRegsW;
  endfunction

  // A dropping chip-select discards any byte completing in the same cycle.
  assign byte_valid = ss_active_i & rx_done_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ss_active_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StCmd;
        StCmd:   if (rx_done_i) state_d = rx_data_i[7] ? StWdata : StRdata;
        StWdata: state_d = StWdata;
        StRdata: state_d = StRdata;
        default: state_d = StIdle;
      endcase
    end
  end

  // Out-of-range pointers hold so the rest of the frame stays harmless.
  always_comb begin
    addr_adv = addr_q;
    if (in_range(addr_q)) begin
      addr_adv = (addr_q == LastAddr) ? 4'h0 : addr_q + 4'h1;
    end
    rd_addr = (state_q == StCmd) ? rx_data_i[3:0] : addr_adv;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (rd_addr == 4'h0) begin
      rd_byte = ID_VALUE;
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rd_addr == 4'(i)) rd_byte = regs_q[i];
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_load_d  = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    addr_err_d = 1'b0;
    reg_we     = 1'b0;
    if (byte_valid) begin
      unique case (state_q)
        StCmd: begin
          addr_d     = rx_data_i[3:0];
          addr_err_d = !in_range(rx_data_i[3:0]);
          if (!rx_data_i[7]) begin
            tx_data_d = rd_byte;
            tx_load_d = 1'b1;
          end
        end
        StWdata: begin
          if (in_range(addr_q) && (addr_q != 4'h0)) begin
            reg_we    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_data_i;
          end
          addr_d = addr_adv;
        end
        StRdata: begin
          addr_d    = addr_adv;
          tx_data_d = rd_byte;
          tx_load_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= 4'h0;
      tx_data_q  <= 8'h00;
      tx_load_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 4'h0;
      wr_data_q  <= 8'h00;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_load_q  <= tx_load_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (reg_we && (addr_q == 4'(i))) regs_q[i] <= rx_data_i;
      end
    end
  end

  always_comb begin
    regs_out_o      = '0;
    regs_out_o[7:0] = ID_VALUE;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_out_o[8*i +: 8] = regs_q[i];
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_load_o  = tx_load_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign addr_err_o = addr_err_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed, table-driven bench for spi_reg_ctrl with NUM_REGS=8 and ID 0xA5.
module tb_spi_reg_ctrl;

  localparam int unsigned NumRegs = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ss_active;
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic [7:0]           tx_data;
  logic                 tx_load;
  logic                 wr_en;
  logic [3:0]           wr_addr;
  logic [7:0]           wr_data;
  logic [NumRegs*8-1:0] regs_out;
  logic                 busy;
  logic                 addr_err;

  int checks = 0;
  int failures = 0;

  spi_reg_ctrl #(
    .NUM_REGS(NumRegs),
    .ID_VALUE(8'hA5)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ss_active_i(ss_active),
    .rx_data_i  (rx_data),
    .rx_done_i  (rx_done),
    .tx_data_o  (tx_data),
    .tx_load_o  (tx_load),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .regs_out_o (regs_out),
    .busy_o     (busy),
    .addr_err_o (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       dn;
    logic [7:0] rxd;
    logic       busy;
    logic       txl;
    logic [7:0] txd;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       aerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ss, input logic dn, input logic [7:0] rxd,
                             input logic b, input logic txl, input logic [7:0] txd,
                             input logic we, input logic [3:0] wa, input logic [7:0] wd,
                             input logic aerr);
    vec_t r;
    r.ss = ss; r.dn = dn; r.rxd = rxd; r.busy = b; r.txl = txl; r.txd = txd;
    r.we = we; r.wa = wa; r.wd = wd; r.aerr = aerr;
    return r;
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
  task automatic step(input logic ss, input logic dn, input logic [7:0] rxd);
    @(negedge clk);
    ss_active = ss;
    rx_done   = dn;
    rx_data   = rxd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic b, input logic txl,
                            input logic [7:0] txd, input logic we, input logic [3:0] wa,
                            input logic [7:0] wd, input logic aerr);
    checks++;
    if ({busy, tx_load, tx_data, wr_en, wr_addr, wr_data, addr_err} !==
        {b, txl, txd, we, wa, wd, aerr}) begin
      failures++;
      $display("FAIL %s: got busy=%b txl=%b txd=%h we=%b wa=%h wd=%h aerr=%b, want busy=%b txl=%b txd=%h we=%b wa=%h wd=%h aerr=%b",
               name, busy, tx_load, tx_data, wr_en, wr_addr, wr_data, addr_err,
               b, txl, txd, we, wa, wd, aerr);
    end
  endtask

  task automatic check_regs(input string name, input logic [NumRegs*8-1:0] exp);
    checks++;
    if (regs_out !== exp) begin
      failures++;
      $display("FAIL %s: regs_out got %h want %h", name, regs_out, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    ss_active = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;

    //                ss dn rxd    busy txl txd   we wa    wd     aerr
    // Read reg0 then one dummy
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(v(1, 1, 8'h00, 1, 1, 8'hA5, 0, 4'h0, 8'h00, 0));
    vecs.push_back(v(1, 1, 8'hFF, 1, 1, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    // Burst write 0x82: 11 22 (back-to-back), gap, 33
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(v(1, 1, 8'h82, 1, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(v(1, 1, 8'h11, 1, 0, 8'h00, 1, 4'h2, 8'h11, 0));
    vecs.push_back(v(1, 1, 8'h22, 1, 0, 8'h00, 1, 4'h3, 8'h22, 0));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h3, 8'h22, 0));
    vecs.push_back(v(1, 1, 8'h33, 1, 0, 8'h00, 1, 4'h4, 8'h33, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 4'h4, 8'h33, 0));
    // Wrap write 0x87: AA -> reg7, BB -> reg0 (ignored), CC -> reg1
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h4, 8'h33, 0));
    vecs.push_back(v(1, 1, 8'h87, 1, 0, 8'h00, 0, 4'h4, 8'h33, 0));
    vecs.push_back(v(1, 1, 8'hAA, 1, 0, 8'h00, 1, 4'h7, 8'hAA, 0));
    vecs.push_back(v(1, 1, 8'hBB, 1, 0, 8'h00, 0, 4'h7, 8'hAA, 0));
    vecs.push_back(v(1, 1, 8'hCC, 1, 0, 8'h00, 1, 4'h1, 8'hCC, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 4'h1, 8'hCC, 0));
    // Burst read from 6: 00, AA, A5, CC
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 1, 8'h06, 1, 1, 8'h00, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 1, 8'h00, 1, 1, 8'hAA, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 1, 8'h00, 1, 1, 8'hA5, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 1, 8'h00, 1, 1, 8'hCC, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'hCC, 0, 4'h1, 8'hCC, 0));
    // Out-of-range write 0x8C then read 0x0C
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'hCC, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 1, 8'h8C, 1, 0, 8'hCC, 0, 4'h1, 8'hCC, 1));
    vecs.push_back(v(1, 1, 8'h55, 1, 0, 8'hCC, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'hCC, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'hCC, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(1, 1, 8'h0C, 1, 1, 8'h00, 0, 4'h1, 8'hCC, 1));
    vecs.push_back(v(1, 1, 8'h00, 1, 1, 8'h00, 0, 4'h1, 8'hCC, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 4'h1, 8'hCC, 0));

    #3;
    check_outs("reset_outputs", 0, 0, 8'h00, 0, 4'h0, 8'h00, 0);
    check_regs("reset_regs", 64'h0000_0000_0000_00A5);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ss, vecs[i].dn, vecs[i].rxd);
      check_outs($sformatf("row%0d", i), vecs[i].busy, vecs[i].txl, vecs[i].txd,
                 vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].aerr);
    end
    check_regs("regs_after_table", 64'hAA00_0033_2211_CCA5);

    // Chip-select drops together with the second data byte's rx_done
    step(1, 0, 8'h00);
    step(1, 1, 8'h85);
    step(1, 1, 8'h77);
    check_outs("abort_first_write", 1, 0, 8'h00, 1, 4'h5, 8'h77, 0);
    step(0, 1, 8'h99);
    check_outs("abort_drop", 0, 0, 8'h00, 0, 4'h5, 8'h77, 0);
    check_regs("abort_regs", 64'hAA00_7733_2211_CCA5);

    // Asynchronous reset in the middle of a write frame
    step(1, 0, 8'h00);
    step(1, 1, 8'h83);
    step(1, 1, 8'h44);
    check_outs("pre_reset_write", 1, 0, 8'h00, 1, 4'h3, 8'h44, 0);
    check_regs("pre_reset_regs", 64'hAA00_7733_4411_CCA5);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset_outputs", 0, 0, 8'h00, 0, 4'h0, 8'h00, 0);
    check_regs("async_reset_regs", 64'h0000_0000_0000_00A5);
    @(negedge clk);
    rst_n     = 1'b1;
    ss_active = 1'b0;
    rx_done   = 1'b0;
    step(0, 0, 8'h00);
    check_outs("post_reset_idle", 0, 0, 8'h00, 0, 4'h0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
